video_tx_gen: RTL

VIDEO_TX_GEN -- requirements
Module: video_tx_gen

---
 rtl/video_tx_gen.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/video_tx_gen.sv
// video_tx_gen: frame/line timing generator that reads pixels from a line
// buffer and emits vsync/hsync/den with pixel data.
// The FSM runs three cycles ahead of the timing outputs so the line-buffer
// read (o_mem_cen) leads each o_den by exactly two cycles without stretching
// pixel spacing.
// Optional feature macro: VIDEO_TX_TEST_PATTERN_EN adds i_pat_en, which
// selects a pixel+line index pattern in place of memory data.
module video_tx_gen #(
  parameter int IO_BW     = 10,
  parameter int ADDR_BW   = 12,
  parameter int FS_BW     = 13,
  parameter int VS_W      = 1,
  parameter int HS_W      = 1,
  parameter int DEN_GAP   = 1,
  parameter int LINE_TAIL = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [3:0]         i_frames,
  input  logic [FS_BW-1:0]   i_vsize,
  input  logic [FS_BW-1:0]   i_hsize,
  input  logic [9:0]         i_vblank,
  input  logic [9:0]         i_hblank,
`ifdef VIDEO_TX_TEST_PATTERN_EN
  input  logic               i_pat_en,
`endif
  output logic               o_mem_cen,
  output logic [ADDR_BW-1:0] o_mem_addr,
  input  logic [IO_BW-1:0]   i_mem_rdata,
  output logic               o_vsync,
  output logic               o_hsync,
  output logic               o_den,
  output logic [IO_BW-1:0]   o_data,
  output logic               o_busy,
  output logic               o_frame_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_VSYNC, S_VBLANK_F, S_HSYNC, S_HBLANK,
    S_PIXEL, S_GAP, S_TAIL, S_VBLANK_B
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q;
  logic [FS_BW-1:0]   pix_q, line_q;
  logic [3:0]         frame_q;
  logic [3:0]         frames_q;
  logic [FS_BW-1:0]   vsize_q, hsize_q;
  logic [9:0]         vblank_q, hblank_q;
  logic               pat_q;
  logic               pat_start;

  logic [15:0]        seg_len;
  logic               seg_last;
  logic               frame_cmp;
  logic               last_frame;
  logic               fd_c;
  logic               start_ok;
  logic [FS_BW:0]     pat_sum;
  logic [IO_BW-1:0]   pat_c;

  logic               vs_p0, vs_p1, hs_p0, hs_p1, den_p0, den_p1;
  logic               fd_p0, fd_p1, fdl_p0, fdl_p1, fdl_p2;
  logic [IO_BW-1:0]   pat_p0, pat_p1;

`ifdef VIDEO_TX_TEST_PATTERN_EN
  assign pat_start = i_pat_en;
`else
  assign pat_start = 1'b0;
`endif

  assign start_ok   = (state_q == S_IDLE) && !o_busy && i_start && (i_frames != 4'd0);
  assign last_frame = (frame_q == frames_q - 4'd1);
  assign pat_sum    = {1'b0, pix_q} + {1'b0, line_q};
  assign pat_c      = IO_BW'(pat_sum);

  // Segment length of the current state and the state that follows it
  always_comb begin
    seg_len   = 16'd1;
    state_d   = state_q;
    frame_cmp = 1'b0;
    case (state_q)
      S_VSYNC:    seg_len = 16'(VS_W);
      S_VBLANK_F: seg_len = 16'(vblank_q);
      S_VBLANK_B: seg_len = 16'(vblank_q);
      S_HSYNC:    seg_len = 16'(HS_W);
      S_HBLANK:   seg_len = 16'(hblank_q);
      S_GAP:      seg_len = 16'(DEN_GAP);
      S_TAIL:     seg_len = 16'(LINE_TAIL);
      default:    seg_len = 16'd1;
    endcase
    case (state_q)
      S_VSYNC: begin
        if (vblank_q != 10'd0)     state_d = S_VBLANK_F;
        else if (vsize_q != '0)    state_d = S_HSYNC;
        else                       frame_cmp = 1'b1;
      end
      S_VBLANK_F: state_d = (vsize_q != '0) ? S_HSYNC : S_VBLANK_B;
      S_HSYNC: begin
        if (hblank_q != 10'd0)     state_d = S_HBLANK;
        else if (hsize_q != '0)    state_d = S_PIXEL;
        else                       state_d = S_TAIL;
      end
      S_HBLANK:   state_d = (hsize_q != '0) ? S_PIXEL : S_TAIL;
      S_PIXEL:    state_d = S_GAP;
      S_GAP:      state_d = (pix_q == hsize_q - FS_BW'(1)) ? S_TAIL : S_PIXEL;
      S_TAIL: begin
        if (line_q != vsize_q - FS_BW'(1)) state_d = S_HSYNC;
        else if (vblank_q != 10'd0)        state_d = S_VBLANK_B;
        else                               frame_cmp = 1'b1;
      end
      S_VBLANK_B: frame_cmp = 1'b1;
      default:    state_d = S_IDLE;
    endcase
    if (frame_cmp) state_d = last_frame ? S_IDLE : S_VSYNC;
  end

  assign seg_last = (cnt_q == seg_len - 16'd1);
  assign fd_c     = (state_q != S_IDLE) && seg_last && frame_cmp;

  // Timing FSM: latches configuration on start and walks frame/line segments
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pix_q    <= '0;
      line_q   <= '0;
      frame_q  <= '0;
      frames_q <= '0;
      vsize_q  <= '0;
      hsize_q  <= '0;
      vblank_q <= '0;
      hblank_q <= '0;
      pat_q    <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (start_ok) begin
        frames_q <= i_frames;
        vsize_q  <= i_vsize;
        hsize_q  <= i_hsize;
        vblank_q <= i_vblank;
        hblank_q <= i_hblank;
        pat_q    <= pat_start;
        cnt_q    <= '0;
        pix_q    <= '0;
        line_q   <= '0;
        frame_q  <= '0;
        state_q  <= S_VSYNC;
      end
    end else if (seg_last) begin
      cnt_q   <= '0;
      state_q <= state_d;
      if (state_q == S_GAP) pix_q <= pix_q + FS_BW'(1);
      if (state_q == S_TAIL) begin
        pix_q  <= '0;
        line_q <= line_q + FS_BW'(1);
      end
      if (frame_cmp) begin
        pix_q   <= '0;
        line_q  <= '0;
        frame_q <= frame_q + 4'd1;
      end
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Output pipeline: memory read issued now, timing outputs three cycles later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_mem_cen    <= 1'b0;
      o_mem_addr   <= '0;
      vs_p0 <= 1'b0; vs_p1 <= 1'b0; hs_p0 <= 1'b0; hs_p1 <= 1'b0;
      den_p0 <= 1'b0; den_p1 <= 1'b0; fd_p0 <= 1'b0; fd_p1 <= 1'b0;
      fdl_p0 <= 1'b0; fdl_p1 <= 1'b0; fdl_p2 <= 1'b0;
      pat_p0 <= '0; pat_p1 <= '0;
      o_vsync      <= 1'b0;
      o_hsync      <= 1'b0;
      o_den        <= 1'b0;
      o_data       <= '0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_mem_cen  <= (state_q == S_PIXEL) && !pat_q;
      o_mem_addr <= ((state_q == S_PIXEL) && !pat_q) ? ADDR_BW'(pix_q) : '0;
      vs_p0  <= (state_q == S_VSYNC);
      hs_p0  <= (state_q == S_HSYNC);
      den_p0 <= (state_q == S_PIXEL);
      fd_p0  <= fd_c;
      fdl_p0 <= fd_c && last_frame;
      pat_p0 <= pat_c;
      vs_p1  <= vs_p0;
      hs_p1  <= hs_p0;
      den_p1 <= den_p0;
      fd_p1  <= fd_p0;
      fdl_p1 <= fdl_p0;
      pat_p1 <= pat_p0;
      o_vsync      <= vs_p1;
      o_hsync      <= hs_p1;
      o_den        <= den_p1;
      o_frame_done <= fd_p1;
      fdl_p2       <= fdl_p1;
      o_data       <= den_p1 ? (pat_q ? pat_p1 : i_mem_rdata) : '0;
      if (start_ok)    o_busy <= 1'b1;
      else if (fdl_p2) o_busy <= 1'b0;
    end
  end

endmodule
